// File: rtl/branch_unit_bht.sv
// Branch resolution unit with a direct-mapped BHT of 2-bit saturating counters.
// Resolves RV32/RV64 conditional branches, trains the BHT on every resolved
// branch and reports registered resolve/mispredict pulses plus statistics.
module branch_unit_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pred_pc,
    output logic              pred_taken,
    input  logic              res_valid,
    input  logic [XLEN-1:0]   res_pc,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic              Branch,
    input  logic [2:0]        funct3,
    input  logic              res_pred_taken,
    output logic              BrTaken,
    output logic              res_taken_q,
    output logic              res_done_q,
    output logic              mispredict_q,
    output logic [STAT_W-1:0] branch_cnt,
    output logic [STAT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Counter storage kept in flops so the asynchronous reset reaches every entry.
    logic [1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;

    logic resolve;
    logic cmp_eq;
    logic cmp_lt_s;
    logic cmp_lt_u;
    logic cond_true;

    logic [1:0]        cur_cnt;
    logic [1:0]        next_cnt;
    logic [STAT_W-1:0] branch_cnt_next;
    logic [STAT_W-1:0] mispred_cnt_next;
    logic              mispredict;

    // PC bits outside the index field do not take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:IDX_W+2],  res_pc[1:0]};

    // Word-aligned PCs: the two low bits never select an entry.
    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    // A resolve happens only for a valid conditional branch.
    assign resolve = res_valid & Branch;

    // Fetch-side read sees the stored value; an update this cycle lands next cycle.
    assign pred_taken = bht[pred_idx][1];

    // Full-width comparators shared by all six branch conditions.
    assign cmp_eq   = (A == B);
    assign cmp_lt_s = ($signed(A) < $signed(B));
    assign cmp_lt_u = (A < B);

    // Select the branch condition; reserved funct3 codes resolve as not taken.
    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            F3_BEQ:  cond_true = cmp_eq;
            F3_BNE:  cond_true = ~cmp_eq;
            F3_BLT:  cond_true = cmp_lt_s;
            F3_BGE:  cond_true = ~cmp_lt_s;
            F3_BLTU: cond_true = cmp_lt_u;
            F3_BGEU: cond_true = ~cmp_lt_u;
            default: cond_true = 1'b0;
        endcase
    end

    assign BrTaken    = resolve & cond_true;
    assign mispredict = resolve & (BrTaken != res_pred_taken);

    // Saturating up/down step for the counter being trained.
    always_comb begin
        cur_cnt  = bht[res_idx];
        next_cnt = cur_cnt;
        if (BrTaken) begin
            if (cur_cnt != 2'b11) begin
                next_cnt = cur_cnt + 2'b01;
            end
        end else begin
            if (cur_cnt != 2'b00) begin
                next_cnt = cur_cnt - 2'b01;
            end
        end
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_comb begin
        branch_cnt_next  = branch_cnt;
        mispred_cnt_next = mispred_cnt;
        if (resolve && (branch_cnt != {STAT_W{1'b1}})) begin
            branch_cnt_next = branch_cnt + STAT_W'(1);
        end
        if (mispredict && (mispred_cnt != {STAT_W{1'b1}})) begin
            mispred_cnt_next = mispred_cnt + STAT_W'(1);
        end
    end

    // Train the indexed counter on every resolve; reset returns all to CNT_INIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (resolve) begin
            bht[res_idx] <= next_cnt;
        end
    end

    // One-cycle resolve/mispredict pulses; the outcome holds between resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_done_q   <= 1'b0;
            mispredict_q <= 1'b0;
            res_taken_q  <= 1'b0;
        end else begin
            res_done_q   <= resolve;
            mispredict_q <= mispredict;
            if (resolve) begin
                res_taken_q <= BrTaken;
            end
        end
    end

    // Performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            branch_cnt  <= branch_cnt_next;
            mispred_cnt <= mispred_cnt_next;
        end
    end

endmodule

// File: tb/tb_branch_unit_bht.sv
// Bench for branch_unit_bht: a default 32-bit instance and a 64-bit instance
// with a 16-entry BHT and 4-bit statistics, both driven by the same stimulus
// and compared against a behavioural model of the branch/BHT rules.
module tb_branch_unit_bht;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_pred;
    logic [63:0] pc_res;
    logic [63:0] a_op;
    logic [63:0] b_op;
    logic        res_valid;
    logic        branch;
    logic [2:0]  funct3;
    logic        res_pred_taken;

    logic        pt32, bt32, tq32, dq32, mq32;
    logic [31:0] bc32, mc32;
    logic        pt64, bt64, tq64, dq64, mq64;
    logic [3:0]  bc64, mc64;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(64), .CNT_INIT(2'b01), .STAT_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .pred_pc(pc_pred[31:0]), .pred_taken(pt32),
        .res_valid(res_valid), .res_pc(pc_res[31:0]),
        .A(a_op[31:0]), .B(b_op[31:0]),
        .Branch(branch), .funct3(funct3), .res_pred_taken(res_pred_taken),
        .BrTaken(bt32), .res_taken_q(tq32), .res_done_q(dq32), .mispredict_q(mq32),
        .branch_cnt(bc32), .mispred_cnt(mc32)
    );

    branch_unit_bht #(.XLEN(64), .BHT_ENTRIES(16), .CNT_INIT(2'b01), .STAT_W(4)) dut64 (
        .clk(clk), .rst(rst),
        .pred_pc(pc_pred), .pred_taken(pt64),
        .res_valid(res_valid), .res_pc(pc_res),
        .A(a_op), .B(b_op),
        .Branch(branch), .funct3(funct3), .res_pred_taken(res_pred_taken),
        .BrTaken(bt64), .res_taken_q(tq64), .res_done_q(dq64), .mispredict_q(mq64),
        .branch_cnt(bc64), .mispred_cnt(mc64)
    );

    // Observed outputs gathered per instance so the checks can loop.
    logic        oPt [2];
    logic        oBt [2];
    logic        oTq [2];
    logic        oDq [2];
    logic        oMq [2];
    logic [63:0] oBc [2];
    logic [63:0] oMc [2];

    assign oPt[0] = pt32;  assign oPt[1] = pt64;
    assign oBt[0] = bt32;  assign oBt[1] = bt64;
    assign oTq[0] = tq32;  assign oTq[1] = tq64;
    assign oDq[0] = dq32;  assign oDq[1] = dq64;
    assign oMq[0] = mq32;  assign oMq[1] = mq64;
    assign oBc[0] = {32'b0, bc32};  assign oBc[1] = {60'b0, bc64};
    assign oMc[0] = {32'b0, mc32};  assign oMc[1] = {60'b0, mc64};

    // Reference model state: counter values 0..3, plain event counts.
    int              entries [2] = '{64, 16};
    int              xlen    [2] = '{32, 64};
    longint unsigned statMax [2] = '{64'hFFFF_FFFF, 64'd15};
    int              mBht    [2][64];
    longint unsigned mBr     [2];
    longint unsigned mMp     [2];
    bit              mTq     [2];
    bit              mDq     [2];
    bit              mMq     [2];

    // Count a comparison and report any difference.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int idxOf(input logic [63:0] pc, input int n);
        longint unsigned word;
        word = pc >> 2;
        return int'(word % longint'(n));
    endfunction

    // Branch outcome computed from the RISC-V condition definitions.
    function automatic bit refOutcome(input logic [2:0] f3, input logic [63:0] a,
                                      input logic [63:0] b, input int w);
        longint          sa, sb;
        longint unsigned ua, ub;
        if (w == 32) begin
            sa = longint'($signed(a[31:0]));
            sb = longint'($signed(b[31:0]));
            ua = {32'b0, a[31:0]};
            ub = {32'b0, b[31:0]};
        end else begin
            sa = $signed(a);
            sb = $signed(b);
            ua = a;
            ub = b;
        end
        case (f3)
            3'd0:    return ua == ub;
            3'd1:    return ua != ub;
            3'd4:    return sa < sb;
            3'd5:    return sa >= sb;
            3'd6:    return ua < ub;
            3'd7:    return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int e = 0; e < 64; e++) mBht[i][e] = 1;
            mBr[i] = 0;
            mMp[i] = 0;
            mTq[i] = 0;
            mDq[i] = 0;
            mMq[i] = 0;
        end
    endfunction

    task automatic checkPred(input logic [63:0] pp, input string when);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("pred_taken%0d_%s", xlen[i], when), oPt[i],
                        mBht[i][idxOf(pp, entries[i])] >= 2);
        end
    endtask

    task automatic checkRegs(input string when);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("res_done_q%0d_%s", xlen[i], when), oDq[i], mDq[i]);
            checkOutput($sformatf("mispredict_q%0d_%s", xlen[i], when), oMq[i], mMq[i]);
            checkOutput($sformatf("res_taken_q%0d_%s", xlen[i], when), oTq[i], mTq[i]);
            checkOutput($sformatf("branch_cnt%0d_%s", xlen[i], when), oBc[i], mBr[i]);
            checkOutput($sformatf("mispred_cnt%0d_%s", xlen[i], when), oMc[i], mMp[i]);
        end
    endtask

    // One cycle of stimulus, entered and left 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [63:0] pp, input logic [63:0] rp,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic v, input logic br,
                                 input logic [2:0] f3, input logic rpt);
        bit taken [2];
        bit ev;
        int k;
        pc_pred = pp;
        pc_res = rp;
        a_op = a;
        b_op = b;
        res_valid = v;
        branch = br;
        funct3 = f3;
        res_pred_taken = rpt;
        ev = v & br;
        #2;
        for (int i = 0; i < 2; i++) begin
            taken[i] = ev ? refOutcome(f3, a, b, xlen[i]) : 1'b0;
            checkOutput($sformatf("BrTaken%0d_f3_%0d", xlen[i], f3), oBt[i], taken[i]);
        end
        checkPred(pp, "pre");
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (ev) begin
                k = idxOf(rp, entries[i]);
                if (taken[i]) mBht[i][k] = (mBht[i][k] < 3) ? mBht[i][k] + 1 : 3;
                else          mBht[i][k] = (mBht[i][k] > 0) ? mBht[i][k] - 1 : 0;
                if (mBr[i] < statMax[i]) mBr[i]++;
                if (taken[i] != rpt && mMp[i] < statMax[i]) mMp[i]++;
                mTq[i] = taken[i];
                mDq[i] = 1'b1;
                mMq[i] = (taken[i] != rpt);
            end else begin
                mDq[i] = 1'b0;
                mMq[i] = 1'b0;
            end
        end
        checkRegs("post");
        checkPred(pp, "post");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] pa, pb, rp, pp;
        rst = 1'b1;
        pc_pred = '0;
        pc_res = '0;
        a_op = '0;
        b_op = '0;
        res_valid = 1'b0;
        branch = 1'b0;
        funct3 = '0;
        res_pred_taken = 1'b0;
        modelReset();

        // Reset state is visible while reset is still held.
        #3;
        checkRegs("in_reset");
        checkPred(64'h0, "in_reset");
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Every entry predicts not taken after reset.
        for (int e = 0; e < 64; e++) begin
            pc_pred = 64'(e * 4);
            #1;
            checkPred(pc_pred, "sweep");
        end
        checkRegs("after_reset");
        @(posedge clk);
        #1;

        // Condition table at both widths, including signed/unsigned corners.
        for (int f = 0; f < 8; f++) begin
            applyStimulus(64'h84 + 64'(4 * f), 64'h84 + 64'(4 * f), 64'hFFFF_FFFF, 64'd1,
                          1'b1, 1'b1, 3'(f), 1'b0);
        end
        for (int f = 0; f < 8; f++) begin
            applyStimulus(64'h0, 64'h84 + 64'(4 * f), 64'h8000_0000_0000_0000, 64'd1,
                          1'b1, 1'b1, 3'(f), 1'b1);
        end

        // Same-index read and train: old value this cycle, new value next cycle.
        applyStimulus(64'h40, 64'h40, 64'd7, 64'd7, 1'b1, 1'b1, 3'b000, 1'b0);
        applyStimulus(64'h40 + 64'd256, 64'h8, 64'd0, 64'd0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Saturate one counter upward, then drive it down to strongly not taken.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(64'h100, 64'h100, 64'd3, 64'd3, 1'b1, 1'b1, 3'b000, 1'b0);
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus(64'h100, 64'h100, 64'd3, 64'd4, 1'b1, 1'b1, 3'b000, 1'b0);
        end
        applyStimulus(64'h100, 64'h0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b000, 1'b0);

        // Statistics saturation on the 4-bit instance, then a non-branch cycle.
        for (int n = 0; n < 20; n++) begin
            applyStimulus(64'h0, 64'(n * 4), 64'd9, 64'd9, 1'b1, 1'b1, 3'b000, 1'b0);
        end
        applyStimulus(64'h0, 64'h10, 64'd9, 64'd9, 1'b1, 1'b0, 3'b000, 1'b1);
        applyStimulus(64'h0, 64'h10, 64'd9, 64'd9, 1'b0, 1'b1, 3'b000, 1'b1);

        // Asynchronous reset in the middle of a taken resolve.
        applyStimulus(64'h24, 64'h24, 64'd5, 64'd5, 1'b1, 1'b1, 3'b000, 1'b0);
        applyStimulus(64'h24, 64'h24, 64'd5, 64'd5, 1'b1, 1'b1, 3'b000, 1'b1);
        pc_pred = 64'h24;
        pc_res = 64'h24;
        a_op = 64'd5;
        b_op = 64'd5;
        res_valid = 1'b1;
        branch = 1'b1;
        funct3 = 3'b000;
        res_pred_taken = 1'b0;
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkRegs("async_rst");
        checkPred(64'h24, "async_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        res_valid = 1'b0;
        branch = 1'b0;
        @(posedge clk);
        #1;
        checkRegs("after_rst");
        checkPred(64'h24, "after_rst");

        // Randomised traffic with frequent index collisions and high PC bits.
        for (int n = 0; n < 400; n++) begin
            rp = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                             : 64'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
            pp = ($urandom_range(0, 2) == 0) ? rp : {$urandom, $urandom_range(0, 255)};
            pa = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       pb = pa;
                1:       pb = pa ^ 64'h8000_0000_8000_0000;
                2:       pb = pa + 64'd1;
                default: pb = {$urandom, $urandom};
            endcase
            applyStimulus(pp, rp, pa, pb,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/branch_unit_bht.md
Name: branch_unit_bht

Overview:
Parametrised branch resolution unit for the RISC-V core.
- Resolves the six RV32/RV64 conditional branches (beq, bne, blt, bge, bltu, bgeu) at configurable operand width XLEN.
- Holds a direct-mapped branch history table (BHT) of 2-bit saturating counters. The fetch stage reads predictions from it; the execute stage trains it on resolution.
- Produces a registered resolve/mispredict pulse for the flush logic, plus saturating performance counters.

Parameters:
XLEN, 32, operand and PC width (32 or 64).
BHT_ENTRIES, 64, number of BHT counters; power of two, >= 2.
CNT_INIT, 2'b01, counter reset value (weakly not-taken).
STAT_W, 32, width of performance counters.

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pred_pc  input  XLEN  fetch-stage PC to predict
pred_taken  output  1  combinational prediction: MSB of BHT[idx(pred_pc)]
res_valid  input  1  execute-stage instruction valid this cycle
res_pc  input  XLEN  PC of resolving instruction
A  input  XLEN  rs1 operand
B  input  XLEN  rs2 operand
Branch  input  1  instruction is a conditional branch
funct3  input  3  branch condition select
res_pred_taken  input  1  prediction originally made for this instruction
BrTaken  output  1  combinational resolved outcome
res_taken_q  output  1  BrTaken registered, valid with res_done_q
res_done_q  output  1  one-cycle pulse: a branch resolved last cycle
mispredict_q  output  1  one-cycle pulse: resolved outcome != res_pred_taken
branch_cnt  output  STAT_W  resolved branches, saturating
mispred_cnt  output  STAT_W  mispredictions, saturating

Behaviour:
Index and outcome:
- idx(pc) = pc[IDX_W+1:2], where IDX_W = log2(BHT_ENTRIES). Bits [1:0] are ignored.
- BrTaken = 0 unless (res_valid & Branch).
- When (res_valid & Branch), BrTaken is selected by funct3:
  - 000: A == B
  - 001: A != B
  - 100: signed A < B
  - 101: signed A >= B
  - 110: unsigned A < B
  - 111: unsigned A >= B
  - 010 and 011: 0
- All comparisons span the full XLEN.

Resolve event:
- A resolve event is (res_valid & Branch). Illegal funct3 values still count as a resolve event with outcome 0.
- Non-branch cycles (Branch=0 or res_valid=0) leave all state unchanged and produce no pulses. This holds even if res_pred_taken=1.

Per resolve event, at the next rising edge:
- Counter BHT[idx(res_pc)]: incremented if BrTaken, else decremented. Saturates at 2'b11 and 2'b00.
- res_done_q = 1 and res_taken_q = BrTaken.
- mispredict_q = (BrTaken != res_pred_taken).
- branch_cnt increments. mispred_cnt increments when mispredicting. Both hold at all-ones (no wrap).
- On cycles with no resolve event: res_done_q = 0, mispredict_q = 0, res_taken_q holds its value.

Read/write ordering:
- pred_taken is a combinational read with no bypass.
- If pred_pc and res_pc map to the same index in one cycle, pred_taken shows the pre-update value. The updated value is visible from the next cycle.

Latency:
- BrTaken: 0 cycles.
- res_done_q, mispredict_q, res_taken_q, counters: 1 cycle.

Reset (asynchronous; effective immediately, including mid-resolve):
- All BHT entries = CNT_INIT.
- res_taken_q, res_done_q, mispredict_q = 0.
- branch_cnt, mispred_cnt = 0.
- pred_taken = CNT_INIT[1].
- A resolve presented in the same cycle that rst is high is discarded.
- Normal operation resumes on the first rising edge after rst deasserts.

Storage: the BHT is a flop array so that the asynchronous reset covers every entry. No SRAM is used.

Test Plan:
1. Reset, then sweep pred_pc over all entries -> pred_taken = 0 everywhere. branch_cnt = 0, mispred_cnt = 0, res_done_q = 0.
2. Conditions at XLEN=32:
   - A=0xFFFFFFFF, B=1, funct3=100 -> BrTaken = 1.
   - Same operands, funct3=110 -> BrTaken = 0.
   - funct3=011 -> BrTaken = 0, but branch_cnt still increments.
   - Repeat the signed/unsigned pair at XLEN=64 with A=0x8000_0000_0000_0000, B=1.
3. Saturation at res_pc=0x100 (BEQ taken, res_pred_taken=0):
   - Cycle 1: counter 01->10; mispredict_q = 1 the next cycle.
   - Cycle 2: counter 10->11.
   - Cycle 3: counter stays 11.
   - Then 4 not-taken resolves -> counter 00, and pred_taken(0x100) = 0.
4. Same-cycle collision: pred_pc = res_pc = 0x40, counter = 01, taken resolve -> pred_taken = 0 that cycle, 1 the next. Aliased pc 0x40 + 4*BHT_ENTRIES reads the same counter.
5. Stats saturation with STAT_W=4: 20 mispredicted branches -> branch_cnt = 15, mispred_cnt = 15. res_valid=1 with Branch=0 and res_pred_taken=1 -> no pulse, counts unchanged.
6. Assert rst asynchronously mid-cycle during a taken resolve -> outputs clear before the next edge, the BHT entry stays 01, and the resolve is not counted.
